// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between the ID stage, the dcache controller and the pipeline-register
// enables that surrounds the hazard/stall controller.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             idex_memread_i;
    logic [4:0]       idex_rt_i;
    logic [4:0]       ifid_rs_i;
    logic [4:0]       ifid_rt_i;
    logic             mem_req_i;
    logic             cache_hit_i;
    logic             mem_ack_i;
    logic             hd_o;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             pipe_stall_o;
    logic [CNT_W-1:0] miss_cnt_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic             err_o;

    // Pipeline/cache side: drives the status inputs, consumes the enables.
    modport master (
        output idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
        output mem_req_i, cache_hit_i, mem_ack_i,
        input  hd_o, pc_write_o, ifid_write_o, pipe_stall_o,
        input  miss_cnt_o, stall_cnt_o, err_o
    );

    // Controller side.
    modport slave (
        input  idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
        input  mem_req_i, cache_hit_i, mem_ack_i,
        output hd_o, pc_write_o, ifid_write_o, pipe_stall_o,
        output miss_cnt_o, stall_cnt_o, err_o
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// ID-stage bubble select and pipeline write enables: combinational load-use
// detection plus a dcache-miss freeze FSM, saturating counters and timeout flag.
module hazard_stall_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk_i,
    input  logic               rst_i,
    hazard_stall_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_WAIT = 2'd1,
        RETRY     = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(TIMEOUT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             err_q, err_d;

    logic miss_seen;
    logic stall;
    logic raw;
    logic hd;

    // The freeze starts in the very cycle the miss is seen, before the FSM moves.
    always_comb begin
        miss_seen = (state_q == IDLE) && bus.mem_req_i && !bus.cache_hit_i;
        stall     = miss_seen || (state_q != IDLE);
        raw       = bus.idex_memread_i && (bus.idex_rt_i != 5'd0) &&
                    ((bus.idex_rt_i == bus.ifid_rs_i) || (bus.idex_rt_i == bus.ifid_rt_i));
        hd        = raw && !stall;
    end

    assign bus.hd_o         = hd;
    assign bus.pipe_stall_o = stall;
    assign bus.pc_write_o   = !(hd || stall);
    assign bus.ifid_write_o = !(hd || stall);
    assign bus.miss_cnt_o   = miss_cnt_q;
    assign bus.stall_cnt_o  = stall_cnt_q;
    assign bus.err_o        = err_q;

    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (miss_seen) begin
                    state_d = MISS_WAIT;
                    wait_d  = '0;
                end
            end
            MISS_WAIT: begin
                if (bus.mem_ack_i) begin
                    state_d = RETRY;
                end else begin
                    // Timeout only flags; the refill may still arrive late.
                    if (wait_q == WAIT_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end
            RETRY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        miss_cnt_d  = miss_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (miss_seen && (miss_cnt_q != CNT_MAX)) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
        end
        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            miss_cnt_q  <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            miss_cnt_q  <= miss_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (CNT_W=16/TIMEOUT=1023 and
// CNT_W=4/TIMEOUT=3) share stimulus and are compared to a cycle-count model.
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       memread = 1'b0;
    logic [4:0] ex_rt   = 5'd0;
    logic [4:0] id_rs   = 5'd0;
    logic [4:0] id_rt   = 5'd0;
    logic       req     = 1'b0;
    logic       hit     = 1'b0;
    logic       ack     = 1'b0;

    hazard_stall_ctrl_if #(.CNT_W(16)) bus_a ();
    hazard_stall_ctrl_if #(.CNT_W(4))  bus_b ();

    assign bus_a.idex_memread_i = memread;
    assign bus_a.idex_rt_i      = ex_rt;
    assign bus_a.ifid_rs_i      = id_rs;
    assign bus_a.ifid_rt_i      = id_rt;
    assign bus_a.mem_req_i      = req;
    assign bus_a.cache_hit_i    = hit;
    assign bus_a.mem_ack_i      = ack;
    assign bus_b.idex_memread_i = memread;
    assign bus_b.idex_rt_i      = ex_rt;
    assign bus_b.ifid_rs_i      = id_rs;
    assign bus_b.ifid_rt_i      = id_rt;
    assign bus_b.mem_req_i      = req;
    assign bus_b.cache_hit_i    = hit;
    assign bus_b.mem_ack_i      = ack;

    hazard_stall_ctrl #(.CNT_W(16), .TIMEOUT(1023)) dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));
    hazard_stall_ctrl #(.CNT_W(4),  .TIMEOUT(3))    dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));

    int checks = 0;
    int errors = 0;

    // Model: miss in progress, waiting cycles seen, one-cycle retry, plain integer counts.
    int lim_to[2]   = '{1023, 3};
    int lim_cnt[2]  = '{65535, 15};
    bit m_wait[2];
    bit m_retry[2];
    bit m_err[2];
    int m_waited[2];
    int m_miss[2];
    int m_stall[2];
    bit exp_stall[2];

    function automatic int sat(input int n, input int m);
        return (n > m) ? m : n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_wait[k]   = 1'b0;
            m_retry[k]  = 1'b0;
            m_err[k]    = 1'b0;
            m_waited[k] = 0;
            m_miss[k]   = 0;
            m_stall[k]  = 0;
        end
    endtask

    task automatic step(input string tag, input bit r, input bit mr, input logic [4:0] xrt,
                        input logic [4:0] irs, input logic [4:0] irt,
                        input bit rq, input bit h, input bit a);
        bit        raw;
        bit        exp_hd;
        bit        miss_now;
        logic [31:0] obs [7];
        @(negedge clk);
        rst = r; memread = mr; ex_rt = xrt; id_rs = irs; id_rt = irt;
        req = rq; hit = h; ack = a;
        if (r) model_reset();
        #1;
        raw = mr && (xrt != 5'd0) && (xrt == irs || xrt == irt);
        for (int k = 0; k < 2; k++) begin
            miss_now     = !m_wait[k] && !m_retry[k] && rq && !h;
            exp_stall[k] = miss_now || m_wait[k] || m_retry[k];
            exp_hd       = raw && !exp_stall[k];
            if (k == 0) begin
                obs = '{32'(bus_a.pipe_stall_o), 32'(bus_a.hd_o), 32'(bus_a.pc_write_o),
                        32'(bus_a.ifid_write_o), 32'(bus_a.miss_cnt_o), 32'(bus_a.stall_cnt_o),
                        32'(bus_a.err_o)};
            end else begin
                obs = '{32'(bus_b.pipe_stall_o), 32'(bus_b.hd_o), 32'(bus_b.pc_write_o),
                        32'(bus_b.ifid_write_o), 32'(bus_b.miss_cnt_o), 32'(bus_b.stall_cnt_o),
                        32'(bus_b.err_o)};
            end
            check($sformatf("%s[%0d].stall", tag, k), obs[0], 32'(exp_stall[k]));
            check($sformatf("%s[%0d].hd", tag, k), obs[1], 32'(exp_hd));
            check($sformatf("%s[%0d].pc_write", tag, k), obs[2], 32'(!(exp_hd || exp_stall[k])));
            check($sformatf("%s[%0d].ifid_write", tag, k), obs[3], 32'(!(exp_hd || exp_stall[k])));
            check($sformatf("%s[%0d].miss_cnt", tag, k), obs[4], 32'(sat(m_miss[k], lim_cnt[k])));
            check($sformatf("%s[%0d].stall_cnt", tag, k), obs[5], 32'(sat(m_stall[k], lim_cnt[k])));
            check($sformatf("%s[%0d].err", tag, k), obs[6], 32'(m_err[k]));
        end
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (exp_stall[k]) m_stall[k]++;
                if (m_retry[k]) begin
                    m_retry[k] = 1'b0;
                end else if (m_wait[k]) begin
                    if (a) begin
                        m_wait[k]  = 1'b0;
                        m_retry[k] = 1'b1;
                    end else begin
                        // The (TIMEOUT+1)-th unacknowledged waiting cycle raises the flag.
                        if (m_waited[k] >= lim_to[k]) m_err[k] = 1'b1;
                        m_waited[k]++;
                    end
                end else if (rq && !h) begin
                    m_wait[k]   = 1'b1;
                    m_waited[k] = 0;
                    m_miss[k]++;
                end
            end
        end
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();

        // Reset state
        step("rst", 1, 0, 0, 0, 0, 0, 0, 0);
        step("rst", 1, 0, 0, 0, 0, 0, 0, 0);
        idle("idle");

        // Load-use hazards
        step("lu_rs", 0, 1, 5, 5, 0, 0, 0, 0);
        step("lu_rt0", 0, 1, 0, 0, 0, 0, 0, 0);
        step("lu_rt", 0, 1, 9, 3, 9, 0, 0, 0);
        step("lu_noload", 0, 0, 9, 9, 9, 0, 0, 0);
        step("lu_nomatch", 0, 1, 9, 3, 4, 0, 1, 0);

        // Miss, acknowledged on the fourth cycle after the miss
        step("miss", 0, 0, 0, 0, 0, 1, 0, 0);
        step("wait", 0, 0, 0, 0, 0, 0, 0, 0);
        step("wait", 0, 0, 0, 0, 0, 0, 0, 0);
        step("wait", 0, 0, 0, 0, 0, 0, 0, 0);
        step("ack", 0, 0, 0, 0, 0, 0, 0, 1);
        step("retry", 0, 0, 0, 0, 0, 1, 0, 1);
        idle("release");

        // Miss with simultaneous load-use hazard
        step("mh_miss", 0, 1, 7, 7, 0, 1, 0, 0);
        step("mh_wait", 0, 1, 7, 7, 0, 0, 0, 0);
        step("mh_ack", 0, 1, 7, 7, 0, 0, 0, 1);
        step("mh_retry", 0, 1, 7, 7, 0, 0, 0, 0);
        step("mh_bubble", 0, 1, 7, 7, 0, 0, 0, 0);
        idle("mh_after");

        // Long wait: small instance times out early, large one after 1024 cycles
        step("to_miss", 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 1026; i++) step("to_wait", 0, 0, 0, 0, 0, 0, 0, 0);
        step("to_ack", 0, 0, 0, 0, 0, 0, 0, 1);
        step("to_retry", 0, 0, 0, 0, 0, 0, 0, 0);
        idle("to_idle");
        idle("to_idle");

        // Reset in the middle of a miss wait, with a new miss pending
        step("rm_miss", 0, 0, 0, 0, 0, 1, 0, 0);
        step("rm_wait", 0, 0, 0, 0, 0, 0, 0, 0);
        step("rm_rst", 1, 0, 0, 0, 0, 1, 0, 0);
        step("rm_rst", 1, 1, 6, 6, 0, 1, 0, 0);
        idle("rm_idle");

        // Back-to-back misses drive the small counters into saturation
        for (int i = 0; i < 20; i++) begin
            step("sat_miss", 0, 0, 0, 0, 0, 1, 0, 0);
            step("sat_ack", 0, 0, 0, 0, 0, 1, 0, 1);
            step("sat_retry", 0, 0, 0, 0, 0, 1, 0, 0);
        end
        idle("sat_idle");

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            step("rand", ($urandom_range(0, 99) == 0),
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0);
        end
        idle("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
